table_loader: RTL



---
 rtl/table_loader_pkg.sv | 15 +
 rtl/table_regfile.sv | 52 +++++
 rtl/table_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/table_loader_pkg.sv
// Shared constants and FSM state encoding for the coefficient table loader.
// Widths match the lookup ROM this block replaces.
package table_loader_pkg;

  localparam int TBL_DEPTH = 10;
  localparam int TBL_WIDTH = 10;
  localparam int TBL_AW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/table_regfile.sv
// DEPTH x WIDTH register-file table: one synchronous write port and one
// combinational read port that returns zero when deselected or out of range.
module table_regfile
  import table_loader_pkg::*;
#(
  parameter int DEPTH = TBL_DEPTH,
  parameter int WIDTH = TBL_WIDTH,
  parameter int AW    = TBL_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cs,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Entries are individual flops so the whole table clears on reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Decoding against each valid index leaves addresses DEPTH..2^AW-1 at zero.
  always_comb begin
    rdata = '0;
    if (cs) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr == AW'(i)) begin
          rdata = mem[i];
        end
      end
    end
  end

endmodule

// File: rtl/table_loader.sv
// Streams DEPTH coefficient words over valid/ready into a run-time writable
// table that exposes the lookup ROM's cs/address/data read port.
module table_loader
  import table_loader_pkg::*;
#(
  parameter int DEPTH = TBL_DEPTH,
  parameter int WIDTH = TBL_WIDTH,
  parameter int AW    = TBL_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [AW-1:0]    wr_addr,
  output logic             busy,
  output logic             done,
  input  logic             cs,
  input  logic [AW-1:0]    address,
  output logic [WIDTH-1:0] data
);

  state_t          state_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic            wr_ready_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            we;
  logic            last_word;

  // A restart pulse takes priority over a handshake in the same cycle.
  assign we        = wr_valid && wr_ready_reg && !start;
  assign last_word = (wr_addr_reg == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_addr_reg  <= '0;
      wr_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            wr_addr_reg  <= '0;
            wr_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            wr_addr_reg <= '0;
          end else if (wr_valid) begin
            if (last_word) begin
              state_reg    <= ST_DONE;
              wr_addr_reg  <= '0;
              wr_ready_reg <= 1'b0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              wr_addr_reg <= wr_addr_reg + AW'(1);
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          wr_addr_reg  <= '0;
          wr_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready = wr_ready_reg;
  assign wr_addr  = wr_addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  table_regfile #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wr_addr_reg),
    .wdata(wr_data),
    .cs   (cs),
    .raddr(address),
    .rdata(data)
  );

endmodule
